cellram_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single cellram controller slave port. Master 0 is the video cache refill port and master 1 is the CPU BIU data port. Video normally wins, but a starvation guard guarantees the CPU a tenure after a bounded number of video tenures. A bus watchdog terminates hung cycles with an error.

---
 rtl/cellram_wb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_cellram_wb_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the single cellram controller slave.
// Master 0 (video cache refill) normally wins; a starvation guard hands master 1
// (CPU BIU) the bus after STARVE_MAX consecutive m0 tenures granted while m1 waited.
// A watchdog aborts a tenure whose strobe sees no ack for TIMEOUT cycles.
//
// Ports:
//   wb_clk_i, wb_rst_n_i             bus clock, asynchronous active-low reset
//   wb_m0_* / wb_m1_*                master ports (adr/dat/sel/cyc/stb/we in, dat/ack/err out)
//   wb_s_*                           slave port towards the cellram controller
//   mst_sel_o                        current owner: 00 none, 01 m0, 10 m1
//   timeout_o                        one-cycle pulse when the watchdog aborts a tenure
module cellram_wb_arbiter #(
  parameter int unsigned ADR_W      = 32,
  parameter int unsigned DAT_W      = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  // master 0: video cache
  input  logic [ADR_W-1:0]   wb_m0_adr_i,
  input  logic [DAT_W-1:0]   wb_m0_dat_i,
  input  logic [DAT_W/8-1:0] wb_m0_sel_i,
  input  logic               wb_m0_cyc_i,
  input  logic               wb_m0_stb_i,
  input  logic               wb_m0_we_i,
  output logic [DAT_W-1:0]   wb_m0_dat_o,
  output logic               wb_m0_ack_o,
  output logic               wb_m0_err_o,
  // master 1: CPU BIU
  input  logic [ADR_W-1:0]   wb_m1_adr_i,
  input  logic [DAT_W-1:0]   wb_m1_dat_i,
  input  logic [DAT_W/8-1:0] wb_m1_sel_i,
  input  logic               wb_m1_cyc_i,
  input  logic               wb_m1_stb_i,
  input  logic               wb_m1_we_i,
  output logic [DAT_W-1:0]   wb_m1_dat_o,
  output logic               wb_m1_ack_o,
  output logic               wb_m1_err_o,
  // slave: cellram controller
  output logic [ADR_W-1:0]   wb_s_adr_o,
  output logic [DAT_W-1:0]   wb_s_dat_o,
  output logic [DAT_W/8-1:0] wb_s_sel_o,
  output logic               wb_s_cyc_o,
  output logic               wb_s_stb_o,
  output logic               wb_s_we_o,
  input  logic [DAT_W-1:0]   wb_s_dat_i,
  input  logic               wb_s_ack_i,
  // status
  output logic [1:0]         mst_sel_o,
  output logic               timeout_o
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
  localparam logic [9:0] WdLimit   = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGnt0 = 2'b01,
    StGnt1 = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [9:0] wd_cnt_q, wd_cnt_d;

  logic owner_cyc;
  logic owner_stb;
  logic wd_abort;

  // Control lines of whichever master currently owns the bus.
  always_comb begin
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    case (state_q)
      StGnt0: begin
        owner_cyc = wb_m0_cyc_i;
        owner_stb = wb_m0_stb_i;
      end
      StGnt1: begin
        owner_cyc = wb_m1_cyc_i;
        owner_stb = wb_m1_stb_i;
      end
      default: ;
    endcase
  end

  // An ack in the limit cycle wins over the abort, so err and ack never coincide.
  assign wd_abort = owner_cyc & owner_stb & ~wb_s_ack_i & (wd_cnt_q == WdLimit);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wd_cnt_d     = '0;
    case (state_q)
      StIdle: begin
        if (wb_m1_cyc_i && (!wb_m0_cyc_i || starve_cnt_q == StarveMax)) begin
          state_d      = StGnt1;
          starve_cnt_d = '0;
        end else if (wb_m0_cyc_i) begin
          state_d = StGnt0;
          if (wb_m1_cyc_i && starve_cnt_q < StarveMax) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
        // m1 not waiting: its starvation history is void
        if (!wb_m1_cyc_i) begin
          starve_cnt_d = '0;
        end
      end
      StGnt0, StGnt1: begin
        // Dropping cyc (even with stb high) just abandons the cycle, no error.
        if (wd_abort || !owner_cyc) begin
          state_d = StIdle;
        end
        if (!(wb_s_ack_i || !owner_stb || wd_abort)) begin
          wd_cnt_d = wd_cnt_q + 10'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  // Slave-side mux decodes from the registered owner only; the abort cycle
  // additionally withdraws cyc/stb so the controller drops the access.
  always_comb begin
    wb_s_adr_o = '0;
    wb_s_dat_o = '0;
    wb_s_sel_o = '0;
    wb_s_we_o  = 1'b0;
    wb_s_cyc_o = 1'b0;
    wb_s_stb_o = 1'b0;
    mst_sel_o  = 2'b00;
    case (state_q)
      StGnt0: begin
        wb_s_adr_o = wb_m0_adr_i;
        wb_s_dat_o = wb_m0_dat_i;
        wb_s_sel_o = wb_m0_sel_i;
        wb_s_we_o  = wb_m0_we_i;
        wb_s_cyc_o = wb_m0_cyc_i & ~wd_abort;
        wb_s_stb_o = wb_m0_stb_i & ~wd_abort;
        mst_sel_o  = 2'b01;
      end
      StGnt1: begin
        wb_s_adr_o = wb_m1_adr_i;
        wb_s_dat_o = wb_m1_dat_i;
        wb_s_sel_o = wb_m1_sel_i;
        wb_s_we_o  = wb_m1_we_i;
        wb_s_cyc_o = wb_m1_cyc_i & ~wd_abort;
        wb_s_stb_o = wb_m1_stb_i & ~wd_abort;
        mst_sel_o  = 2'b10;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; gated by reset so every output reads 0 while in reset.
  assign wb_m0_dat_o = wb_rst_n_i ? wb_s_dat_i : '0;
  assign wb_m1_dat_o = wb_rst_n_i ? wb_s_dat_i : '0;

  assign wb_m0_ack_o = wb_s_ack_i & (state_q == StGnt0);
  assign wb_m1_ack_o = wb_s_ack_i & (state_q == StGnt1);
  assign wb_m0_err_o = wd_abort & (state_q == StGnt0);
  assign wb_m1_err_o = wd_abort & (state_q == StGnt1);
  assign timeout_o   = wd_abort;

endmodule

// File: tb/tb_cellram_wb_arbiter.sv
// Self-checking bench for cellram_wb_arbiter: directed phases plus a random phase,
// all driven through one per-cycle engine that compares the DUT with a
// tenure-level reference model of the arbitration rules.
module tb_cellram_wb_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 255;

  logic        clk;
  logic        rst_n;
  logic [31:0] m_adr   [2];
  logic [31:0] m_dat_w [2];
  logic [3:0]  m_sel   [2];
  logic        m_cyc   [2];
  logic        m_stb   [2];
  logic        m_we    [2];
  logic [31:0] m0_dat_r, m1_dat_r;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic [3:0]  s_sel;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [1:0]  mst_sel;
  logic        timeout;

  cellram_wb_arbiter #(
    .ADR_W      (32),
    .DAT_W      (32),
    .STARVE_MAX (STARVE_MAX),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .wb_m0_adr_i (m_adr[0]),
    .wb_m0_dat_i (m_dat_w[0]),
    .wb_m0_sel_i (m_sel[0]),
    .wb_m0_cyc_i (m_cyc[0]),
    .wb_m0_stb_i (m_stb[0]),
    .wb_m0_we_i  (m_we[0]),
    .wb_m0_dat_o (m0_dat_r),
    .wb_m0_ack_o (m0_ack),
    .wb_m0_err_o (m0_err),
    .wb_m1_adr_i (m_adr[1]),
    .wb_m1_dat_i (m_dat_w[1]),
    .wb_m1_sel_i (m_sel[1]),
    .wb_m1_cyc_i (m_cyc[1]),
    .wb_m1_stb_i (m_stb[1]),
    .wb_m1_we_i  (m_we[1]),
    .wb_m1_dat_o (m1_dat_r),
    .wb_m1_ack_o (m1_ack),
    .wb_m1_err_o (m1_err),
    .wb_s_adr_o  (s_adr),
    .wb_s_dat_o  (s_dat_w),
    .wb_s_sel_o  (s_sel),
    .wb_s_cyc_o  (s_cyc),
    .wb_s_stb_o  (s_stb),
    .wb_s_we_o   (s_we),
    .wb_s_dat_i  (s_dat_r),
    .wb_s_ack_i  (s_ack),
    .mst_sel_o   (mst_sel),
    .timeout_o   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: owner (0 none, 1 m0, 2 m1), watchdog count, m0 streak
  int own, wd, streak;
  // slave model
  int slv_wait, slv_delay, slv_fixed;
  // master models
  int          trans_left[2], beats_cfg[2], beats_left[2], gap_max[2], gap_cnt[2];
  bit          active[2], toggle[2], fix_en[2];
  logic [31:0] fix_adr[2];
  bit          ack_e[2], err_e[2];
  // observed statistics
  int acks[2], errs[2], tos, beats_issued[2];
  int grants[$];
  int prev_sel, cyc_idx, drop_cyc, m1_gnt_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mst_sel"}, 64'(mst_sel), 64'(0));
    chk({tag, "_timeout"}, 64'(timeout), 64'(0));
    chk({tag, "_s_ctl"}, 64'({s_cyc, s_stb, s_we}), 64'(0));
    chk({tag, "_s_bus"}, {s_adr, s_dat_w}, 64'(0));
    chk({tag, "_s_sel"}, 64'(s_sel), 64'(0));
    chk({tag, "_m_term"}, 64'({m0_ack, m0_err, m1_ack, m1_err}), 64'(0));
    chk({tag, "_m_dat"}, {m0_dat_r, m1_dat_r}, 64'(0));
  endtask

  task automatic update_masters();
    logic [31:0] a;
    for (int m = 0; m < 2; m++) begin
      if (active[m]) begin
        if (ack_e[m] || err_e[m]) begin
          if (err_e[m] || beats_left[m] == 1) begin
            active[m]  = 1'b0;
            m_cyc[m]   = 1'b0;
            m_stb[m]   = 1'b0;
            gap_cnt[m] = $urandom_range(0, gap_max[m]);
            if (m == 0) drop_cyc = cyc_idx;
          end else begin
            beats_left[m]--;
            m_adr[m]   = m_adr[m] + 32'd4;
            m_dat_w[m] = $urandom;
            m_stb[m]   = toggle[m] ? 1'($urandom_range(0, 1)) : 1'b1;
          end
        end else if (!m_stb[m]) begin
          m_stb[m] = 1'b1;
        end
      end else if (gap_cnt[m] > 0) begin
        gap_cnt[m]--;
      end else if (trans_left[m] > 0) begin
        trans_left[m]--;
        active[m]       = 1'b1;
        beats_left[m]   = (beats_cfg[m] > 0) ? beats_cfg[m] : int'($urandom_range(1, 4));
        beats_issued[m] += beats_left[m];
        a               = $urandom;
        a[1:0]          = 2'b00;
        m_adr[m]        = fix_en[m] ? fix_adr[m] : a;
        m_we[m]         = fix_en[m] ? 1'b0 : 1'($urandom_range(0, 1));
        m_sel[m]        = 4'($urandom);
        m_dat_w[m]      = $urandom;
        m_cyc[m]        = 1'b1;
        m_stb[m]        = 1'b1;
      end
    end
  endtask

  // One bus cycle: entered at a falling edge with master inputs settled.
  task automatic cycle();
    logic        oc, os, to_e, exp_we;
    logic [31:0] sd, exp_adr, exp_dat;
    logic [3:0]  exp_sel;
    int          nxt_wait, prev_own;
    oc = 1'b0; os = 1'b0; exp_we = 1'b0;
    exp_adr = '0; exp_dat = '0; exp_sel = '0;
    if (own != 0) begin
      oc      = m_cyc[own-1];
      os      = m_stb[own-1];
      exp_adr = m_adr[own-1];
      exp_dat = m_dat_w[own-1];
      exp_sel = m_sel[own-1];
      exp_we  = m_we[own-1];
    end
    s_ack   = oc && os && (slv_wait == slv_delay);
    sd      = $urandom;
    s_dat_r = sd;
    to_e    = oc && os && !s_ack && (wd == TIMEOUT - 1);
    for (int m = 0; m < 2; m++) begin
      ack_e[m] = s_ack && (own == m + 1);
      err_e[m] = to_e && (own == m + 1);
    end
    #1;
    chk("mst_sel", 64'(mst_sel), 64'(own));
    chk("s_cyc", 64'(s_cyc), 64'(oc && !to_e));
    chk("s_stb", 64'(s_stb), 64'(os && !to_e));
    chk("s_we", 64'(s_we), 64'(exp_we));
    chk("s_adr_dat", {s_adr, s_dat_w}, {exp_adr, exp_dat});
    chk("s_sel", 64'(s_sel), 64'(exp_sel));
    chk("m_ack", 64'({m0_ack, m1_ack}), 64'({ack_e[0], ack_e[1]}));
    chk("m_err", 64'({m0_err, m1_err}), 64'({err_e[0], err_e[1]}));
    chk("timeout", 64'(timeout), 64'(to_e));
    chk("m_dat_bcast", {m0_dat_r, m1_dat_r}, {sd, sd});
    if (m0_ack) acks[0]++;
    if (m1_ack) acks[1]++;
    if (m0_err) errs[0]++;
    if (m1_err) errs[1]++;
    if (timeout) tos++;
    if (mst_sel != 2'b00 && prev_sel == 0) begin
      grants.push_back(int'(mst_sel));
      if (mst_sel == 2'b10) m1_gnt_cyc = cyc_idx;
    end
    prev_sel = int'(mst_sel);
    nxt_wait = (oc && os && !s_ack && !to_e) ? slv_wait + 1 : 0;
    @(posedge clk);
    // arbitration rules applied to what was presented before the edge
    prev_own = own;
    if (own == 0) begin
      if (m_cyc[1] && (!m_cyc[0] || streak == STARVE_MAX)) begin
        own    = 2;
        streak = 0;
      end else if (m_cyc[0]) begin
        own = 1;
        if (m_cyc[1] && streak < STARVE_MAX) streak++;
      end
      if (!m_cyc[1]) streak = 0;
    end else if (to_e || !oc) begin
      own = 0;
    end
    wd = (prev_own == 0 || s_ack || !os || to_e) ? 0 : wd + 1;
    @(negedge clk);
    cyc_idx++;
    slv_wait = nxt_wait;
    if (nxt_wait == 0) slv_delay = (slv_fixed >= 0) ? slv_fixed : int'($urandom_range(0, 4));
    update_masters();
  endtask

  task automatic setup(input int t0, input int b0, input bit tg0,
                       input int t1, input int b1, input bit tg1,
                       input int gap, input int sfix);
    trans_left[0] = t0; beats_cfg[0] = b0; toggle[0] = tg0;
    trans_left[1] = t1; beats_cfg[1] = b1; toggle[1] = tg1;
    for (int m = 0; m < 2; m++) begin
      gap_max[m] = gap; fix_en[m] = 1'b0; acks[m] = 0; errs[m] = 0; beats_issued[m] = 0;
    end
    tos       = 0;
    grants.delete();
    slv_fixed = sfix;
    slv_delay = (sfix >= 0) ? sfix : int'($urandom_range(0, 4));
  endtask

  task automatic run_phase(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && !(trans_left[0] == 0 && trans_left[1] == 0 &&
                           !active[0] && !active[1] && own == 0)) begin
      cycle();
      n++;
    end
    chk({tag, "_completed"}, 64'(n < budget), 64'(1));
  endtask

  task automatic reset_model();
    own = 0; wd = 0; streak = 0; slv_wait = 0; prev_sel = 0;
    for (int m = 0; m < 2; m++) begin
      active[m] = 1'b0; trans_left[m] = 0; gap_cnt[m] = 0;
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
    end
  endtask

  // Asynchronous reset asserted mid-cycle while masters still drive their requests.
  task automatic do_reset_check(input string tag);
    #2;
    rst_n   = 1'b0;
    s_dat_r = 32'hDEAD_BEEF;
    s_ack   = 1'b1;
    #1;
    check_zero(tag);
    @(negedge clk);
    reset_model();
    s_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog: bench did not complete");
    $fatal(1, "bench stalled");
  end

  initial begin
    rst_n = 1'b0;
    s_ack = 1'b1;
    s_dat_r = 32'hCAFE_F00D;
    for (int m = 0; m < 2; m++) begin
      m_adr[m] = 32'h1234_5678; m_dat_w[m] = 32'h9ABC_DEF0; m_sel[m] = 4'hF;
      m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = 1'b1;
      gap_max[m] = 0; beats_cfg[m] = 1; toggle[m] = 1'b0; fix_en[m] = 1'b0;
    end
    cyc_idx = 0; drop_cyc = 0; m1_gnt_cyc = 0; slv_fixed = 0; slv_delay = 0;
    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    reset_model();
    s_ack = 1'b0;
    rst_n = 1'b1;

    // m1 alone reads 0x100, slave acks 4 cycles after stb
    setup(0, 1, 1'b0, 1, 1, 1'b0, 0, 4);
    fix_en[1] = 1'b1; fix_adr[1] = 32'h0000_0100;
    run_phase("m1_alone", 40);
    chk("m1_alone_grants", 64'(grants.size()), 64'(1));
    if (grants.size() > 0) chk("m1_alone_owner", 64'(grants[0]), 64'(2));
    chk("m1_alone_acks", 64'({acks[0], acks[1]}), {32'd0, 32'd1});

    // both masters keep requesting: starvation guard order
    setup(8, 1, 1'b0, 2, 1, 1'b0, 0, -1);
    run_phase("starve", 200);
    chk("starve_ngrants", 64'(grants.size()), 64'(10));
    for (int i = 0; i < grants.size() && i < 10; i++) begin
      chk($sformatf("starve_grant%0d", i), 64'(grants[i]), 64'((i % 5 == 4) ? 2 : 1));
    end

    // m0 8-beat burst with stb toggling while m1 waits
    setup(1, 8, 1'b1, 1, 1, 1'b0, 0, -1);
    run_phase("burst", 200);
    chk("burst_ngrants", 64'(grants.size()), 64'(2));
    if (grants.size() == 2) chk("burst_order", 64'({grants[0], grants[1]}), {32'd1, 32'd2});
    chk("burst_m0_acks", 64'(acks[0]), 64'(8));
    chk("burst_m1_gap", 64'(m1_gnt_cyc - drop_cyc), 64'(2));

    // slave never acks: watchdog abort
    setup(1, 1, 1'b0, 0, 1, 1'b0, 0, 5000);
    run_phase("wdog", 400);
    chk("wdog_err", 64'({errs[0], errs[1]}), {32'd1, 32'd0});
    chk("wdog_pulses", 64'(tos), 64'(1));
    chk("wdog_acks", 64'(acks[0]), 64'(0));

    // ack exactly in the watchdog-limit cycle
    setup(1, 1, 1'b0, 0, 1, 1'b0, 0, TIMEOUT - 1);
    run_phase("ack_at_limit", 400);
    chk("ack_at_limit_ack", 64'(acks[0]), 64'(1));
    chk("ack_at_limit_err", 64'({errs[0], tos}), 64'(0));

    // reset mid-tenure of m1
    setup(0, 1, 1'b0, 1, 1, 1'b0, 0, 50);
    for (int i = 0; i < 60 && grants.size() < 1; i++) cycle();
    repeat (3) cycle();
    chk("rst_m1_pre", 64'(grants.size()), 64'(1));
    do_reset_check("rst_mid_m1");

    // build a full m0 streak, reset during the 4th m0 tenure, then m0 must win
    setup(4, 1, 1'b0, 1, 1, 1'b0, 0, 3);
    for (int i = 0; i < 200 && grants.size() < 4; i++) cycle();
    cycle();
    chk("rst_m0_pre_grants", 64'(grants.size()), 64'(4));
    do_reset_check("rst_mid_m0");
    setup(1, 1, 1'b0, 1, 1, 1'b0, 0, 2);
    run_phase("post_reset", 60);
    chk("post_reset_ngrants", 64'(grants.size()), 64'(2));
    if (grants.size() > 0) chk("post_reset_first", 64'(grants[0]), 64'(1));

    // random traffic
    setup(40, 0, 1'b1, 40, 0, 1'b1, 3, -1);
    run_phase("random", 6000);
    chk("random_m0_beats", 64'(acks[0]), 64'(beats_issued[0]));
    chk("random_m1_beats", 64'(acks[1]), 64'(beats_issued[1]));
    chk("random_no_err", 64'({errs[0], errs[1], tos}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
